// File: rtl/cache_tag_ctrl_pkg.sv
// rtl/cache_tag_ctrl_pkg.sv - shared cache widths, FSM state encoding and line mask
package cache_tag_ctrl_pkg;

  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CMP,
    S_MREQ,
    S_MWAIT,
    S_UPD,
    S_RESP
  } state_t;

endpackage

// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - direct-mapped cache lookup/refill controller driving a 64-entry tag store
module cache_tag_ctrl #(
  parameter int ADDR_W   = cache_tag_ctrl_pkg::ADDR_W,
  parameter int INDEX_W  = cache_tag_ctrl_pkg::INDEX_W,
  parameter int OFFSET_W = cache_tag_ctrl_pkg::OFFSET_W,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic                resp_err,
  input  logic                flush_i,
  output logic                busy_o,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_resp_valid,
  input  logic                mem_resp_err,
  output logic [INDEX_W-1:0]  teg_addr_o,
  output logic [TAG_W-1:0]    teg_o,
  output logic                teg_valid_o,
  output logic                teg_ena_o,
  input  logic [TAG_W-1:0]    teg_data_i,
  input  logic                teg_data_valid_i
);
  import cache_tag_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LINE_MASK_L = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  state_t               state, state_nx;
  logic [INDEX_W-1:0]   cnt;
  logic [ADDR_W-1:0]    lat_addr;
  logic                 flush_pending;
  logic                 ena_c;
  logic                 flush_req;
  logic                 tag_hit;
  logic [TAG_W-1:0]     lat_tag;
  logic [INDEX_W-1:0]   lat_idx;

  assign lat_tag   = lat_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign lat_idx   = lat_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign flush_req = flush_pending | flush_i;
  assign tag_hit   = teg_data_valid_i && (teg_data_i == lat_tag);

  // The tag store has no reset of its own, so the write enable is gated by
  // reset to guarantee nothing lands in it while rst_n is held low.
  assign teg_ena_o    = ena_c & rst_n;
  assign resp_valid   = (state == S_RESP);
  assign busy_o       = (state != S_IDLE);
  assign mem_req_addr = lat_addr & LINE_MASK_L;

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    ena_c         = 1'b0;
    teg_o         = '0;
    teg_valid_o   = 1'b0;
    teg_addr_o    = lat_idx;
    mem_req_valid = 1'b0;
    case (state)
      S_INIT: begin
        ena_c      = 1'b1;
        teg_addr_o = cnt;
        if (&cnt) state_nx = S_IDLE;
      end
      S_IDLE: begin
        // Index comes straight from the request so the registered read data
        // is ready for the compare in the very next cycle.
        teg_addr_o = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
        req_ready  = !flush_req;
        if (flush_req)      state_nx = S_INIT;
        else if (req_valid) state_nx = S_CMP;
      end
      S_CMP:   state_nx = tag_hit ? S_RESP : S_MREQ;
      S_MREQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nx = S_MWAIT;
      end
      S_MWAIT: begin
        if (mem_resp_valid) state_nx = mem_resp_err ? S_RESP : S_UPD;
      end
      S_UPD: begin
        ena_c       = 1'b1;
        teg_o       = lat_tag;
        teg_valid_o = 1'b1;
        state_nx    = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_INIT;
      cnt           <= '0;
      lat_addr      <= '0;
      flush_pending <= 1'b0;
      resp_hit      <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) cnt <= cnt + 1'b1;
      if (state == S_IDLE && req_ready && req_valid) lat_addr <= req_addr;
      if (state_nx == S_INIT && state != S_INIT) flush_pending <= 1'b0;
      else if (flush_i && state != S_IDLE)       flush_pending <= 1'b1;
      if (state == S_CMP) begin
        resp_hit <= tag_hit;
        resp_err <= 1'b0;
      end else if (state == S_MWAIT && mem_resp_valid) begin
        resp_hit <= 1'b0;
        resp_err <= mem_resp_err;
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb/tb_cache_tag_ctrl.sv - directed self-checking bench for cache_tag_ctrl with a tag store model
module tb_cache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_hit;
  logic        resp_err;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic        mem_resp_err = 1'b0;
  logic [5:0]  teg_addr_o;
  logic [21:0] teg_o;
  logic        teg_valid_o;
  logic        teg_ena_o;
  logic [21:0] teg_data_i;
  logic        teg_data_valid_i;

  int tests = 0;
  int fails = 0;
  int ena_cnt = 0;
  int mreq_cnt = 0;
  int snap;

  logic [22:0] store [64];
  logic [22:0] rd_q = '0;

  always #5 clk = ~clk;

  cache_tag_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_err(resp_err),
    .flush_i(flush_i), .busy_o(busy_o),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err),
    .teg_addr_o(teg_addr_o), .teg_o(teg_o), .teg_valid_o(teg_valid_o), .teg_ena_o(teg_ena_o),
    .teg_data_i(teg_data_i), .teg_data_valid_i(teg_data_valid_i)
  );

  // Tag store: write-enable port plus registered read, contents garbage at power-up.
  initial for (int i = 0; i < 64; i++) store[i] = {1'b1, 22'($urandom)};
  always @(posedge clk) begin
    if (teg_ena_o) store[teg_addr_o] <= {teg_valid_o, teg_o};
    rd_q <= store[teg_addr_o];
    if (teg_ena_o) ena_cnt <= ena_cnt + 1;
    if (mem_req_valid) mreq_cnt <= mreq_cnt + 1;
  end
  assign teg_data_i       = rd_q[21:0];
  assign teg_data_valid_i = rd_q[22];

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle of INIT; walks the 64 invalidating writes.
  task automatic sweep(input string name);
    for (int i = 0; i < 64; i++) begin
      #1;
      check({name, "_ena"}, 32'(teg_ena_o), 32'd1);
      check({name, "_addr"}, 32'(teg_addr_o), 32'(i));
      check({name, "_vld"}, 32'(teg_valid_o), 32'd0);
      check({name, "_rdy"}, 32'(req_ready), 32'd0);
      tick();
    end
    #1;
    check({name, "_rdy_after"}, 32'(req_ready), 32'd1);
    check({name, "_busy_after"}, 32'(busy_o), 32'd0);
  endtask

  task automatic send_req(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    check("req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Entered in CMP for an address expected to miss; leaves the DUT in RESP.
  task automatic miss(input logic [31:0] a, input logic err, input logic flush_mid);
    #1;
    check("miss_cmp_resp_valid", 32'(resp_valid), 32'd0);
    tick();
    check("miss_mreq_valid", 32'(mem_req_valid), 32'd1);
    check("miss_mreq_addr", mem_req_addr, a & 32'hFFFF_FFF0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("miss_mwait_mreq", 32'(mem_req_valid), 32'd0);
    snap = ena_cnt;
    mem_resp_valid = 1'b1;
    mem_resp_err   = err;
    flush_i        = flush_mid;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    flush_i        = 1'b0;
    if (!err) begin
      check("upd_ena", 32'(teg_ena_o), 32'd1);
      check("upd_addr", 32'(teg_addr_o), 32'(a[9:4]));
      check("upd_tag", 32'(teg_o), 32'(a[31:10]));
      check("upd_vld", 32'(teg_valid_o), 32'd1);
      tick();
    end
    check("miss_resp_valid", 32'(resp_valid), 32'd1);
    check("miss_resp_hit", 32'(resp_hit), 32'd0);
    check("miss_resp_err", 32'(resp_err), 32'(err));
    check("miss_tag_writes", 32'(ena_cnt - snap), err ? 32'd0 : 32'd1);
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  task automatic hit(input logic [31:0] a);
    snap = mreq_cnt;
    send_req(a);
    check("hit_cmp_resp_valid", 32'(resp_valid), 32'd0);
    tick();
    check("hit_resp_valid", 32'(resp_valid), 32'd1);
    check("hit_resp_hit", 32'(resp_hit), 32'd1);
    check("hit_resp_err", 32'(resp_err), 32'd0);
    check("hit_no_mreq", 32'(mreq_cnt - snap), 32'd0);
    take_resp();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_resp_hit", 32'(resp_hit), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd1);
    check("rst_teg_ena", 32'(teg_ena_o), 32'd0);
    check("rst_teg_o", 32'(teg_o), 32'd0);
    check("rst_teg_vld", 32'(teg_valid_o), 32'd0);
    check("rst_mem_addr", mem_req_addr, 32'd0);

    // 1: post-reset sweep
    rst_n = 1'b1;
    sweep("init");

    // 2: cold miss and refill
    send_req(32'h0000_1230);
    miss(32'h0000_1230, 1'b0, 1'b0);
    take_resp();

    // 3: hit, then same-index conflict overwriting the tag
    hit(32'h0000_1238);
    send_req(32'h0000_1630);
    miss(32'h0000_1630, 1'b0, 1'b0);
    take_resp();
    hit(32'h0000_1630);

    // 4: refill error writes nothing, so the re-request misses again
    send_req(32'h0000_2000);
    miss(32'h0000_2000, 1'b1, 1'b0);
    take_resp();
    send_req(32'h0000_2000);
    miss(32'h0000_2000, 1'b0, 1'b0);
    take_resp();

    // 5: flush during MWAIT with a stalled requester
    send_req(32'h0000_3000);
    miss(32'h0000_3000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_resp_valid", 32'(resp_valid), 32'd1);
      check("stall_resp_hit", 32'(resp_hit), 32'd0);
      check("stall_resp_err", 32'(resp_err), 32'd0);
    end
    take_resp();
    req_valid = 1'b1;
    req_addr  = 32'h0000_1630;
    #1;
    check("flush_pend_rdy", 32'(req_ready), 32'd0);
    tick();
    req_valid = 1'b0;
    check("flush_busy", 32'(busy_o), 32'd1);
    sweep("flush");
    send_req(32'h0000_1630);
    miss(32'h0000_1630, 1'b0, 1'b0);
    take_resp();

    // flush_i and req_valid together in IDLE: flush wins
    req_valid = 1'b1;
    req_addr  = 32'h0000_1630;
    flush_i   = 1'b1;
    #1;
    check("idle_flush_rdy", 32'(req_ready), 32'd0);
    tick();
    req_valid = 1'b0;
    flush_i   = 1'b0;
    sweep("idle_flush");

    // 6: reset while in MREQ
    send_req(32'h0000_4440);
    tick();
    check("mreq_valid_pre", 32'(mem_req_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mreq_valid_rst", 32'(mem_req_valid), 32'd0);
    check("mreq_ena_rst", 32'(teg_ena_o), 32'd0);
    check("mreq_busy_rst", 32'(busy_o), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    sweep("rst_mreq");
    send_req(32'h0000_1630);
    miss(32'h0000_1630, 1'b0, 1'b0);
    take_resp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
